// File: rtl/data_cache_pkg.sv
// -----------------------------------------------------------------------------
// data_cache_pkg
// Shared definitions for the data cache: controller state encoding and the
// cache geometry (8 lines x 4 bytes, 8-bit byte address split as
// tag[7:5] / index[4:2] / offset[1:0]).
// -----------------------------------------------------------------------------
package data_cache_pkg;

    localparam int LINES          = 8;
    localparam int BYTES_PER_LINE = 4;
    localparam int TAG_W          = 3;
    localparam int INDEX_W        = 3;
    localparam int OFFSET_W       = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        FETCH     = 2'd2
    } cache_state_t;

endpackage

// File: rtl/cache_line_store.sv
// -----------------------------------------------------------------------------
// cache_line_store
// Tag / valid / dirty / data arrays of the direct-mapped cache.
// Reads are asynchronous on 'index'; writes happen on the rising CLK edge.
//
// Ports
//   CLK, RESET                 clock, asynchronous active-high reset
//   index                      line selected for read and for both write ports
//   line_tag/valid/dirty/data  contents of the selected line
//   hit_we, hit_offset,
//   hit_data                   CPU store hit: write one byte, mark line dirty
//   fill_we, fill_offset,
//   fill_data, fill_last,
//   fill_tag                   refill byte from memory; fill_last completes
//                              the line (valid=1, dirty=0, tag loaded)
// -----------------------------------------------------------------------------
module cache_line_store
    import data_cache_pkg::*;
(
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic [INDEX_W-1:0]                 index,
    output logic [TAG_W-1:0]                   line_tag,
    output logic                               line_valid,
    output logic                               line_dirty,
    output logic [BYTES_PER_LINE-1:0][7:0]     line_data,
    input  logic                               hit_we,
    input  logic [OFFSET_W-1:0]                hit_offset,
    input  logic [7:0]                         hit_data,
    input  logic                               fill_we,
    input  logic [OFFSET_W-1:0]                fill_offset,
    input  logic [7:0]                         fill_data,
    input  logic                               fill_last,
    input  logic [TAG_W-1:0]                   fill_tag
);

    logic [LINES-1:0]                     valid;
    logic [LINES-1:0]                     dirty;
    logic [TAG_W-1:0]                     tags [LINES];
    logic [BYTES_PER_LINE-1:0][7:0]       data [LINES];

    assign line_tag   = tags[index];
    assign line_valid = valid[index];
    assign line_dirty = dirty[index];
    assign line_data  = data[index];

    // Status bits. Every refill byte clears valid until the last byte lands,
    // so a refill aborted by reset never leaves a half-written line valid.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            valid <= '0;
            dirty <= '0;
        end else if (fill_we) begin
            valid[index] <= fill_last;
            dirty[index] <= 1'b0;
        end else if (hit_we) begin
            dirty[index] <= 1'b1;
        end
    end

    // Payload arrays need no reset: they are only observed through valid.
    always_ff @(posedge CLK) begin
        if (fill_we) begin
            data[index][fill_offset] <= fill_data;
            if (fill_last) begin
                tags[index] <= fill_tag;
            end
        end else if (hit_we) begin
            data[index][hit_offset] <= hit_data;
        end
    end

endmodule

// File: rtl/data_cache.sv
// -----------------------------------------------------------------------------
// data_cache
// Direct-mapped, write-back, write-allocate data cache, 8 lines x 4 bytes,
// between a CPU and a byte-wide data memory.
//
// Ports
//   CLK, RESET                    clock, asynchronous active-high reset
//   cpu_read, cpu_write           CPU access request (both high = store)
//   cpu_address, cpu_writedata    byte address and store data
//   cpu_readdata                  load data, valid while busywait is low
//   busywait                      stall to the CPU
//   mem_read, mem_write,
//   mem_address, mem_writedata    byte request to data memory (registered)
//   mem_readdata, mem_busy        data memory response
// -----------------------------------------------------------------------------
module data_cache
    import data_cache_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic       cpu_read,
    input  logic       cpu_write,
    input  logic [7:0] cpu_address,
    input  logic [7:0] cpu_writedata,
    output logic [7:0] cpu_readdata,
    output logic       busywait,
    output logic       mem_read,
    output logic       mem_write,
    output logic [7:0] mem_address,
    output logic [7:0] mem_writedata,
    input  logic [7:0] mem_readdata,
    input  logic       mem_busy
);

    cache_state_t                   state, state_next;
    logic [OFFSET_W-1:0]            beat, beat_next;
    logic                           seen_busy, seen_busy_next;
    logic                           mem_read_next, mem_write_next;
    logic [7:0]                     mem_address_next, mem_writedata_next;

    logic [TAG_W-1:0]               tag;
    logic [INDEX_W-1:0]             index;
    logic [OFFSET_W-1:0]            offset;
    logic [TAG_W-1:0]               line_tag;
    logic                           line_valid, line_dirty;
    logic [BYTES_PER_LINE-1:0][7:0] line_data;
    logic                           access, hit, hit_we, fill_we;

    assign tag    = cpu_address[7:5];
    assign index  = cpu_address[4:2];
    assign offset = cpu_address[1:0];

    assign access       = cpu_read | cpu_write;
    assign hit          = line_valid && (line_tag == tag);
    assign busywait     = access & ((state != IDLE) | ~hit);
    assign cpu_readdata = hit ? line_data[offset] : 8'h00;
    assign hit_we       = (state == IDLE) && cpu_write && hit;

    cache_line_store u_store (
        .CLK         (CLK),
        .RESET       (RESET),
        .index       (index),
        .line_tag    (line_tag),
        .line_valid  (line_valid),
        .line_dirty  (line_dirty),
        .line_data   (line_data),
        .hit_we      (hit_we),
        .hit_offset  (offset),
        .hit_data    (cpu_writedata),
        .fill_we     (fill_we),
        .fill_offset (beat),
        .fill_data   (mem_readdata),
        .fill_last   (beat == 2'd3),
        .fill_tag    (tag)
    );

    // Controller registers, including the memory request outputs so that
    // they are glitch-free and held stable across the whole handshake.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            beat          <= '0;
            seen_busy     <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= 8'h00;
            mem_writedata <= 8'h00;
        end else begin
            state         <= state_next;
            beat          <= beat_next;
            seen_busy     <= seen_busy_next;
            mem_read      <= mem_read_next;
            mem_write     <= mem_write_next;
            mem_address   <= mem_address_next;
            mem_writedata <= mem_writedata_next;
        end
    end

    // Each byte transfer: raise the request, wait for mem_busy high, then
    // for mem_busy low; on that low edge capture/finish and drop the
    // request. The following cycle has the request low (the mandatory gap)
    // and re-raises it for the next beat.
    always_comb begin
        state_next         = state;
        beat_next          = beat;
        seen_busy_next     = seen_busy;
        mem_read_next      = mem_read;
        mem_write_next     = mem_write;
        mem_address_next   = mem_address;
        mem_writedata_next = mem_writedata;
        fill_we            = 1'b0;

        case (state)
            IDLE: begin
                if (access && !hit) begin
                    beat_next      = '0;
                    seen_busy_next = 1'b0;
                    if (line_valid && line_dirty) begin
                        state_next         = WRITEBACK;
                        mem_write_next     = 1'b1;
                        mem_address_next   = {line_tag, index, 2'b00};
                        mem_writedata_next = line_data[0];
                    end else begin
                        state_next       = FETCH;
                        mem_read_next    = 1'b1;
                        mem_address_next = {tag, index, 2'b00};
                    end
                end
            end

            WRITEBACK, FETCH: begin
                if (mem_read || mem_write) begin
                    if (!seen_busy) begin
                        if (mem_busy) begin
                            seen_busy_next = 1'b1;
                        end
                    end else if (!mem_busy) begin
                        mem_read_next  = 1'b0;
                        mem_write_next = 1'b0;
                        seen_busy_next = 1'b0;
                        fill_we        = (state == FETCH);
                        beat_next      = beat + 2'd1;
                        if (beat == 2'd3) begin
                            state_next = (state == WRITEBACK) ? FETCH : IDLE;
                        end
                    end
                end else if (state == WRITEBACK) begin
                    mem_write_next     = 1'b1;
                    mem_address_next   = {line_tag, index, beat};
                    mem_writedata_next = line_data[beat];
                end else begin
                    mem_read_next    = 1'b1;
                    mem_address_next = {tag, index, beat};
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_data_cache.sv
// -----------------------------------------------------------------------------
// tb_data_cache
// Self-checking bench for data_cache: behavioural byte memory with a random
// busy latency, a scoreboard of expected memory transactions and load data,
// and a per-cycle protocol monitor on the memory interface.
// -----------------------------------------------------------------------------
module tb_data_cache;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       cpu_read, cpu_write;
    logic [7:0] cpu_address, cpu_writedata;
    logic [7:0] cpu_readdata;
    logic       busywait;
    logic       mem_read, mem_write;
    logic [7:0] mem_address, mem_writedata;
    logic [7:0] mem_readdata = 8'h00;
    logic       mem_busy = 1'b0;

    typedef struct packed {
        logic       wr;
        logic [7:0] addr;
        logic [7:0] data;
    } mem_txn_t;

    mem_txn_t   expMemQ[$];
    logic [7:0] expReadQ[$];
    logic [7:0] mem [256];
    int         testsRun = 0;
    int         testsFailed = 0;
    int         acceptCount = 0;
    int         phase = 0;
    int         busyCnt = 0;

    logic       prevReq = 1'b0;
    logic [16:0] prevTxn = '0;

    data_cache dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .cpu_read      (cpu_read),
        .cpu_write     (cpu_write),
        .cpu_address   (cpu_address),
        .cpu_writedata (cpu_writedata),
        .cpu_readdata  (cpu_readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busy      (mem_busy)
    );

    always #5 CLK = ~CLK;

    // Initial memory image: 0x24..0x27 hold 1..4, everything else a pattern.
    function automatic logic [7:0] expInit(input logic [7:0] a);
        if (a >= 8'h24 && a <= 8'h27) return a - 8'h23;
        return a ^ 8'hC3;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic expectFetch(input logic [7:0] base);
        for (int i = 0; i < 4; i++) expMemQ.push_back({1'b0, base + 8'(i), 8'h00});
    endtask

    // Byte memory working on the falling edge: accept a request, hold busy
    // for 1..3 cycles, drop busy with read data, then require the request to
    // be low on the following falling edge (the gap between transfers).
    always @(negedge CLK or posedge RESET) begin
        if (RESET) begin
            phase    = 0;
            mem_busy = 1'b0;
        end else begin
            case (phase)
                0: if (mem_read || mem_write) begin
                    mem_txn_t e;
                    logic [16:0] obs;
                    obs = {mem_write, mem_address, mem_write ? mem_writedata : 8'h00};
                    if (expMemQ.size() == 0) begin
                        checkOutput("memUnexpected", {15'b0, obs}, 32'hFFFF_FFFF);
                    end else begin
                        e = expMemQ.pop_front();
                        checkOutput("memTxn", {15'b0, obs},
                                    {15'b0, e.wr, e.addr, e.wr ? e.data : 8'h00});
                    end
                    if (mem_write) mem[mem_address] = mem_writedata;
                    acceptCount++;
                    mem_busy = 1'b1;
                    busyCnt  = $urandom_range(0, 2);
                    phase    = 1;
                end
                1: if (busyCnt == 0) begin
                    mem_busy     = 1'b0;
                    mem_readdata = mem[mem_address];
                    phase        = 2;
                end else begin
                    busyCnt--;
                end
                default: begin
                    checkOutput("gapAfterBeat", {31'b0, mem_read | mem_write}, 32'd0);
                    phase = 0;
                end
            endcase
        end
    end

    // Every cycle: never read and write together, and an active request
    // keeps type, address and data unchanged.
    always @(negedge CLK) begin
        if (RESET) begin
            prevReq = 1'b0;
        end else begin
            checkOutput("rwExclusive", {31'b0, mem_read & mem_write}, 32'd0);
            if (prevReq && (mem_read || mem_write)) begin
                checkOutput("reqHeld", {15'b0, mem_write, mem_address, mem_writedata},
                            {15'b0, prevTxn});
            end
            prevReq = mem_read | mem_write;
            prevTxn = {mem_write, mem_address, mem_writedata};
        end
    end

    // One CPU access held until busywait drops; checks stall and load data.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [7:0] addr,
                                 input logic [7:0] wdata, input bit expHit,
                                 input logic [7:0] expData);
        int stalls = 0;
        logic [7:0] e;
        @(posedge CLK); #1;
        cpu_read = rd; cpu_write = wr; cpu_address = addr; cpu_writedata = wdata;
        if (rd && !wr) expReadQ.push_back(expData);
        @(negedge CLK);
        while (busywait && stalls < 300) begin
            stalls++;
            @(negedge CLK);
        end
        checkOutput("busyTimeout", {31'b0, busywait}, 32'd0);
        checkOutput(expHit ? "zeroStall" : "missStall", {31'b0, stalls == 0}, {31'b0, expHit});
        if (rd && !wr) begin
            e = expReadQ.pop_front();
            checkOutput("readData", {24'b0, cpu_readdata}, {24'b0, e});
        end
        @(posedge CLK); #1;
        cpu_read = 1'b0; cpu_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int start;
        int waited;
        for (int i = 0; i < 256; i++) mem[i] = expInit(8'(i));
        cpu_read = 0; cpu_write = 0; cpu_address = 8'h24; cpu_writedata = 0;
        RESET = 1'b1;
        #12;
        checkOutput("rstMemRead",  {31'b0, mem_read}, 32'd0);
        checkOutput("rstMemWrite", {31'b0, mem_write}, 32'd0);
        checkOutput("rstMemAddr",  {24'b0, mem_address}, 32'd0);
        checkOutput("rstMemWdata", {24'b0, mem_writedata}, 32'd0);
        checkOutput("rstBusy",     {31'b0, busywait}, 32'd0);
        checkOutput("rstReaddata", {24'b0, cpu_readdata}, 32'd0);
        @(negedge CLK); RESET = 1'b0;

        // Cold miss, then a hit to the last byte of the line.
        expectFetch(8'h24);
        applyStimulus(1, 0, 8'h24, 8'h00, 0, 8'h01);
        applyStimulus(1, 0, 8'h27, 8'h00, 1, 8'h04);

        // Write hit with no memory traffic, read back.
        applyStimulus(0, 1, 8'h24, 8'hAA, 1, 8'h00);
        applyStimulus(1, 0, 8'h24, 8'h00, 1, 8'hAA);
        checkOutput("noTrafficOnHit", expMemQ.size(), 32'd0);

        // Conflict miss on a dirty line: writeback then refill.
        expMemQ.push_back({1'b1, 8'h24, 8'hAA});
        expMemQ.push_back({1'b1, 8'h25, 8'h02});
        expMemQ.push_back({1'b1, 8'h26, 8'h03});
        expMemQ.push_back({1'b1, 8'h27, 8'h04});
        expectFetch(8'h44);
        applyStimulus(1, 0, 8'h44, 8'h00, 0, expInit(8'h44));
        checkOutput("wbMem24", {24'b0, mem[8'h24]}, 32'h0000_00AA);
        applyStimulus(1, 0, 8'h47, 8'h00, 1, expInit(8'h47));

        // Read and write together act as a write-allocate store.
        expectFetch(8'h08);
        applyStimulus(1, 1, 8'h08, 8'h5C, 0, 8'h00);
        applyStimulus(1, 0, 8'h08, 8'h00, 1, 8'h5C);
        applyStimulus(1, 0, 8'h0B, 8'h00, 1, expInit(8'h0B));

        // Reset during the third refill beat of 0x30.
        for (int i = 0; i < 3; i++) expMemQ.push_back({1'b0, 8'h30 + 8'(i), 8'h00});
        start = acceptCount;
        @(posedge CLK); #1;
        cpu_read = 1'b1; cpu_address = 8'h30;
        waited = 0;
        @(negedge CLK);
        while (acceptCount < start + 3 && waited < 300) begin
            waited++;
            @(negedge CLK);
        end
        checkOutput("beat2Reached", acceptCount - start, 32'd3);
        #2 RESET = 1'b1;
        #1;
        checkOutput("abortMemRead", {31'b0, mem_read}, 32'd0);
        checkOutput("abortMemAddr", {24'b0, mem_address}, 32'd0);
        checkOutput("abortBusy",    {31'b0, busywait}, 32'd1);
        cpu_read = 1'b0; cpu_address = 8'h24;
        #1;
        checkOutput("abortReaddata", {24'b0, cpu_readdata}, 32'd0);
        #2 RESET = 1'b0;
        expMemQ.delete();

        // Full refill again; the dirty 0x08 line was discarded by reset.
        expectFetch(8'h30);
        applyStimulus(1, 0, 8'h30, 8'h00, 0, expInit(8'h30));
        expectFetch(8'h08);
        applyStimulus(1, 0, 8'h08, 8'h00, 0, expInit(8'h08));

        repeat (4) @(posedge CLK);
        checkOutput("memDrained", expMemQ.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 SHALL expose CLK, input, 1, rising-edge clock for all state.
REQ-002 SHALL expose RESET, input, 1, asynchronous active-high reset.
REQ-003 SHALL expose cpu_read, input, 1, CPU load request, held until busywait low.
REQ-004 SHALL expose cpu_write, input, 1, CPU store request, held until busywait low.
REQ-005 SHALL expose cpu_address, input, 8, byte address: tag[7:5], index[4:2], offset[1:0].
REQ-006 SHALL expose cpu_writedata, input, 8, store data.
REQ-007 SHALL expose cpu_readdata, output, 8, load data, valid while busywait low.
REQ-008 SHALL expose busywait, output, 1, stall to CPU.
REQ-009 SHALL expose mem_read, mem_write, output, 1 each, byte-wide data-memory requests.
REQ-010 SHALL expose mem_address, output, 8, and mem_writedata, output, 8.
REQ-011 SHALL expose mem_readdata, input, 8, and mem_busy, input, 1, from data memory.

Function
REQ-012 SHALL be direct-mapped, write-back, write-allocate: 8 lines x 4 bytes, 3-bit tag, valid bit, dirty bit per line.
REQ-013 SHALL drive busywait = (cpu_read|cpu_write) & (state!=IDLE | miss), combinationally.
REQ-014 Read hit SHALL return cpu_readdata combinationally in the same cycle, zero stall.
REQ-015 Write hit SHALL update the byte and set dirty at the next CLK edge, zero stall.
REQ-016 cpu_read and cpu_write both high SHALL be treated as a write.
REQ-017 FSM states: IDLE, WRITEBACK, FETCH; no others.
REQ-018 IDLE -> WRITEBACK on miss with victim valid&dirty; IDLE -> FETCH on miss otherwise.
REQ-019 WRITEBACK SHALL issue 4 byte writes at {victim_tag,index,0..3} in offset order, then -> FETCH.
REQ-020 FETCH SHALL issue 4 byte reads at {tag,index,0..3}, fill line, set valid=1, dirty=0, tag, then -> IDLE.
REQ-021 Memory handshake: request, address, data held constant until mem_busy sampled high then sampled low; byte captured and request dropped on that low edge.
REQ-022 SHALL leave mem_read and mem_write low for at least one cycle between consecutive byte transactions.
REQ-023 SHALL never assert mem_read and mem_write together.
REQ-024 After fill, the pending access SHALL complete as a hit in IDLE (one extra cycle).
REQ-025 A 2-bit beat counter SHALL wrap 3 -> 0 on the state exit.
REQ-026 Changes of cpu_address during a stall are illegal; behaviour not specified.

Reset
REQ-027 RESET SHALL asynchronously force state=IDLE, beat=0, all valid/dirty=0, mem_read=mem_write=0, mem_address=0, mem_writedata=0.
REQ-028 Reset mid-WRITEBACK/FETCH SHALL abort the transfer; dirty data is lost; no partial line is marked valid.
REQ-029 After reset, cpu_readdata SHALL read 0, and busywait SHALL follow REQ-013 (every access misses).

Structure
REQ-030 Shared package SHALL hold state encoding, LINES=8, BYTES_PER_LINE=4, TAG_W=3, INDEX_W=3.
REQ-031 Sub-module cache_line_store (tag/valid/dirty/data arrays, async read, sync write) SHALL be used; FSM stays in data_cache.

Verification
REQ-032 Cold read 0x24 with memory[0x24..0x27]=1..4 -> 4 mem_read beats at 0x24..0x27, readdata=1, then read 0x27 hits with zero stall, readdata=4.
REQ-033 Write 0x24=0xAA after fill -> no mem traffic, dirty set; read 0x24 -> 0xAA.
REQ-034 Read 0x44 (same index, tag 2) with dirty line -> 4 mem_write beats 0x24..0x27 (0xAA,2,3,4) then 4 reads 0x44..0x47.
REQ-035 RESET pulse during FETCH beat 2 -> mem_read low immediately; next read of same address fetches all 4 beats again.
REQ-036 Simultaneous cpu_read and cpu_write to 0x08=0x5C -> treated as write; later read 0x08 returns 0x5C.
REQ-037 Bench SHALL check REQ-023 and REQ-022 on every cycle of every scenario.
